ft601_bus_model: RTL and testbench
==================================

# ft601_bus_model

- Synthesizable responder for the chip side of the FT601 245-synchronous FIFO bus, i.e. the device that `ft601_controller` talks to.
- Holds two word FIFOs:
  - an RX FIFO (host→FPGA) that it presents on the bus when the controller reads;
  - a TX FIFO (FPGA→host) that captures words the controller writes.
- A simple valid/ready "host" port loads RX words and drains TX words.
- Used in loopback benches and FPGA self-test builds in place of the physical FT601.

## Interface

Parameters:
- `DEPTH`, 16: entries per FIFO, power of two, ≥2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock; bus and host sides both on this clock.
- `rst` in 1: synchronous, active-high reset.
- `usb_txe` out 1: 0 = TX FIFO has space (controller may write); 1 = full.
- `usb_rxf` out 1: 0 = RX FIFO has data (controller may read); 1 = empty.
- `usb_wren_l` in 1: active-low write strobe from controller.
- `usb_rden_l` in 1: active-low read strobe from controller.
- `usb_outen_l` in 1: active-low request for the model to drive `data`/`be`.
- `usb_rst_l` in 1: active-low flush request.
- `data` inout 32: FT601 data bus; driven only in DRIVE state, else Z.
- `be` inout 4: byte enables; same drive rule as `data`.
- `host_wr_data` in 32, `host_wr_be` in 4, `host_wr_valid` in 1: RX FIFO load word.
- `host_wr_ready` out 1: RX FIFO not full.
- `host_rd_data` out 32, `host_rd_be` out 4: TX FIFO head.
- `host_rd_valid` out 1: TX FIFO not empty.
- `host_rd_ready` in 1: pop TX FIFO head.
- `err_ovf` out 1: sticky; write strobe while TX full.
- `err_unf` out 1: sticky; read strobe while RX empty.
- `err_cont` out 1: sticky; `usb_wren_l` and `usb_outen_l` both low.
- `stat_wr_cnt` out CNT_W: words captured from the bus.
- `stat_rd_cnt` out CNT_W: words delivered to the bus.

## Operation

Bus state machine (registered):
- **IDLE**
  - `usb_outen_l`=0 → TURN.
  - `usb_wren_l`=0 → WRITE.
  - If both are low: raise `err_cont`, stay IDLE.
- **TURN**: one-cycle bus turnaround, nothing driven. Next state is DRIVE if `usb_outen_l`=0, else IDLE.
- **DRIVE**
  - `data`/`be` = RX FIFO head; all ones if empty.
  - `usb_rden_l`=0 and RX not empty → pop on that edge.
  - `usb_rden_l`=0 and RX empty → set `err_unf`, no pop.
  - `usb_outen_l`=1 → IDLE (bus released that same cycle, combinationally from the sampled input).
- **WRITE**: stays in WRITE while `usb_wren_l`=0, else IDLE.

Push rule:
- TX push happens on any edge where `usb_wren_l`=0, `usb_outen_l`=1 and state ∈ {IDLE, WRITE}. This includes the very edge that enters WRITE, so there is zero-cycle write latency.
- If TX is full, the word is dropped and `err_ovf` is set.

Flags and FIFOs:
- `usb_txe`/`usb_rxf` are decoded from registered occupancy counts, so they update the cycle after the push/pop edge.
- The controller must tolerate one stale cycle: a strobe that hits the now-full or now-empty FIFO takes the error path.
- Host port is standard valid/ready:
  - Push when `host_wr_valid`&`host_wr_ready`.
  - Pop when `host_rd_valid`&`host_rd_ready`.
  - Same-cycle bus and host operations on the same FIFO are legal: occupancy is unchanged, and pointers wrap modulo DEPTH.

Flush:
- `usb_rst_l`=0 sampled → both FIFOs emptied, state → IDLE, counters and error flags kept.
- Host pushes in that cycle are discarded.

Reset values:
- State IDLE, FIFOs empty.
- `usb_txe`=0, `usb_rxf`=1, `host_wr_ready`=1, `host_rd_valid`=0.
- Error flags 0, stat counters 0, `data`/`be` = Z.
- Reset mid-transfer aborts immediately; a partially read word is simply lost.

## Timing

- Read: `usb_outen_l` falls at edge N → TURN at N → DRIVE from N+1.
  - The head is valid on `data` during cycle N+1.
  - The first pop occurs at the edge ending N+1 if `usb_rden_l`=0.
  - After that, one word per cycle.
- Write: one word captured per edge with `usb_wren_l`=0; `host_rd_valid` rises the cycle after the first push.
- Full-to-space latency: 1 cycle after a host pop, `usb_txe` goes 0.

## Configuration

- `FT601_MODEL_STATS_EN` defined: `stat_wr_cnt` increments per successful TX push and `stat_rd_cnt` per successful RX pop. Both wrap at 2^CNT_W, are cleared only by `rst`, and are not cleared by `usb_rst_l`.
- Undefined: both outputs are tied to 0 and no counter logic is built.

## Test plan

- **Reset**: hold `rst` 5 cycles → `usb_txe`=0, `usb_rxf`=1, `data`=Z, all err flags 0.
- **Read burst**: host loads 0xFF00FF00, 0x12345678, be=4'hF; controller drops `usb_outen_l` at edge N, `usb_rden_l` at N+1 for 2 cycles → `data`=0xFF00FF00 in cycle N+1 then 0x12345678; `usb_rxf`=1 one cycle after the last pop; `stat_rd_cnt`=2 (stats build).
- **Write fill**: DEPTH=16, 17 consecutive writes of 0..16 → `usb_txe`=1 after the 16th; word 16 dropped; `err_ovf`=1; host drains 0..15 in order.
- **Simultaneous push/pop**: TX holds 15 words; in one cycle the host pops and the bus writes → occupancy stays 15, `usb_txe` stays 0, order is preserved.
- **Contention and underflow**:
  - `usb_wren_l`=0 and `usb_outen_l`=0 together → `err_cont`=1, no push.
  - Read strobe in DRIVE with RX empty → `err_unf`=1, `data`=0xFFFFFFFF.
- **Flush mid-read**: 4 words in RX, pop 1, pulse `usb_rst_l`=0 → next cycle `usb_rxf`=1, state IDLE, bus Z, `stat_rd_cnt` still 1.

Source files
------------

// File: rtl/ft601_bus_model.sv
// Chip-side responder for the FT601 245-synchronous FIFO bus, with a valid/ready host port.
// Define FT601_MODEL_STATS_EN to build the bus word statistics counters.
module ft601_bus_model #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             usb_txe,
  output logic             usb_rxf,
  input  logic             usb_wren_l,
  input  logic             usb_rden_l,
  input  logic             usb_outen_l,
  input  logic             usb_rst_l,
  inout  wire  [31:0]      data,
  inout  wire  [3:0]       be,
  input  logic [31:0]      host_wr_data,
  input  logic [3:0]       host_wr_be,
  input  logic             host_wr_valid,
  output logic             host_wr_ready,
  output logic [31:0]      host_rd_data,
  output logic [3:0]       host_rd_be,
  output logic             host_rd_valid,
  input  logic             host_rd_ready,
  output logic             err_ovf,
  output logic             err_unf,
  output logic             err_cont,
  output logic [CNT_W-1:0] stat_wr_cnt,
  output logic [CNT_W-1:0] stat_rd_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, TURN, DRIVE, WRITE} state_t;

  state_t        r_state;
  logic [35:0]   r_rxMem [DEPTH];
  logic [35:0]   r_txMem [DEPTH];
  logic [AW-1:0] r_rxWrPtr, r_rxRdPtr, r_txWrPtr, r_txRdPtr;
  logic [AW:0]   r_rxCount, r_txCount;
  logic          r_errOvf, r_errUnf, r_errCont;

  logic          w_flush, w_rxEmpty, w_rxFull, w_txEmpty, w_txFull;
  logic          w_busRead, w_busWrite, w_rxPush, w_rxPop, w_txPush, w_txPop, w_drive;
  logic [35:0]   w_rxHead;

  assign w_flush    = ~usb_rst_l;
  assign w_rxEmpty  = (r_rxCount == '0);
  assign w_rxFull   = (r_rxCount == FULL);
  assign w_txEmpty  = (r_txCount == '0);
  assign w_txFull   = (r_txCount == FULL);
  assign w_busRead  = (r_state == DRIVE) && !usb_rden_l;
  assign w_busWrite = !usb_wren_l && usb_outen_l && (r_state == IDLE || r_state == WRITE);
  assign w_rxPush   = host_wr_valid && !w_rxFull && !w_flush;
  assign w_rxPop    = w_busRead && !w_rxEmpty && !w_flush;
  assign w_txPush   = w_busWrite && !w_txFull && !w_flush;
  assign w_txPop    = host_rd_ready && !w_txEmpty && !w_flush;

  // Bus is released as soon as the controller lifts outen, not a cycle later.
  assign w_drive  = (r_state == DRIVE) && !usb_outen_l;
  assign w_rxHead = w_rxEmpty ? '1 : r_rxMem[r_rxRdPtr];
  assign data     = w_drive ? w_rxHead[31:0]  : 'z;
  assign be       = w_drive ? w_rxHead[35:32] : 'z;

  assign usb_txe       = w_txFull;
  assign usb_rxf       = w_rxEmpty;
  assign host_wr_ready = !w_rxFull;
  assign host_rd_valid = !w_txEmpty;
  assign host_rd_data  = r_txMem[r_txRdPtr][31:0];
  assign host_rd_be    = r_txMem[r_txRdPtr][35:32];
  assign err_ovf       = r_errOvf;
  assign err_unf       = r_errUnf;
  assign err_cont      = r_errCont;

  always_ff @(posedge clk) begin
    if (w_rxPush) r_rxMem[r_rxWrPtr] <= {host_wr_be, host_wr_data};
    if (w_txPush) r_txMem[r_txWrPtr] <= {be, data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rxWrPtr <= '0;
      r_rxRdPtr <= '0;
      r_txWrPtr <= '0;
      r_txRdPtr <= '0;
      r_rxCount <= '0;
      r_txCount <= '0;
      r_errOvf  <= 1'b0;
      r_errUnf  <= 1'b0;
      r_errCont <= 1'b0;
    end else begin
      if (!usb_wren_l && !usb_outen_l) r_errCont <= 1'b1;
      if (w_busWrite && w_txFull)      r_errOvf  <= 1'b1;
      if (w_busRead && w_rxEmpty)      r_errUnf  <= 1'b1;
      // Flush empties both FIFOs but keeps the sticky errors and counters.
      if (w_flush) begin
        r_state   <= IDLE;
        r_rxWrPtr <= '0;
        r_rxRdPtr <= '0;
        r_txWrPtr <= '0;
        r_txRdPtr <= '0;
        r_rxCount <= '0;
        r_txCount <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!usb_outen_l && usb_wren_l)      r_state <= TURN;
            else if (usb_outen_l && !usb_wren_l) r_state <= WRITE;
          end
          TURN:    r_state <= usb_outen_l ? IDLE : DRIVE;
          DRIVE:   if (usb_outen_l) r_state <= IDLE;
          WRITE:   if (usb_wren_l)  r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
        if (w_rxPush) r_rxWrPtr <= r_rxWrPtr + 1'b1;
        if (w_rxPop)  r_rxRdPtr <= r_rxRdPtr + 1'b1;
        if (w_txPush) r_txWrPtr <= r_txWrPtr + 1'b1;
        if (w_txPop)  r_txRdPtr <= r_txRdPtr + 1'b1;
        case ({w_rxPush, w_rxPop})
          2'b10:   r_rxCount <= r_rxCount + 1'b1;
          2'b01:   r_rxCount <= r_rxCount - 1'b1;
          default: ;
        endcase
        case ({w_txPush, w_txPop})
          2'b10:   r_txCount <= r_txCount + 1'b1;
          2'b01:   r_txCount <= r_txCount - 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef FT601_MODEL_STATS_EN
  logic [CNT_W-1:0] r_wrCnt, r_rdCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrCnt <= '0;
      r_rdCnt <= '0;
    end else begin
      if (w_txPush) r_wrCnt <= r_wrCnt + 1'b1;
      if (w_rxPop)  r_rdCnt <= r_rdCnt + 1'b1;
    end
  end

  assign stat_wr_cnt = r_wrCnt;
  assign stat_rd_cnt = r_rdCnt;
`else
  assign stat_wr_cnt = '0;
  assign stat_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_ft601_bus_model.sv
// Directed bench for ft601_bus_model: vector table for the bus state machine plus
// hand-written sequences for bursts, FIFO fill, simultaneous push/pop and flush.
module tb_ft601_bus_model;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
`ifdef FT601_MODEL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             usb_txe, usb_rxf;
  logic             usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l;
  wire  [31:0]      data;
  wire  [3:0]       be;
  logic [31:0]      host_wr_data;
  logic [3:0]       host_wr_be;
  logic             host_wr_valid, host_wr_ready;
  logic [31:0]      host_rd_data;
  logic [3:0]       host_rd_be;
  logic             host_rd_valid, host_rd_ready;
  logic             err_ovf, err_unf, err_cont;
  logic [CNT_W-1:0] stat_wr_cnt, stat_rd_cnt;

  logic             tbDrv;
  logic [31:0]      tbData;
  logic [3:0]       tbBe;

  assign data = tbDrv ? tbData : 'z;
  assign be   = tbDrv ? tbBe   : 'z;

  always #5 clk = ~clk;

  ft601_bus_model #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .usb_txe(usb_txe), .usb_rxf(usb_rxf),
    .usb_wren_l(usb_wren_l), .usb_rden_l(usb_rden_l),
    .usb_outen_l(usb_outen_l), .usb_rst_l(usb_rst_l),
    .data(data), .be(be),
    .host_wr_data(host_wr_data), .host_wr_be(host_wr_be),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_rd_data(host_rd_data), .host_rd_be(host_rd_be),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_cont(err_cont),
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
  );

  typedef struct {
    logic        wrenL;
    logic        outenL;
    logic        rdenL;
    logic [31:0] wrData;
    logic [3:0]  wrBe;
    logic        expCont;
    logic        expUnf;
    logic        expRdValid;
    logic [1:0]  busMode;   // 0: skip, 1: released, 2: driven with expData/4'hF
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [31:0] expStat(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    else
      passes++;
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, 32'(actual), 32'(expected));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a probe pattern; it reads back intact only if the model is not driving.
  task automatic checkBusReleased(input string name);
    tbDrv  = 1'b1;
    tbData = 32'h5A5A5A5A;
    tbBe   = 4'h5;
    #1;
    checkOutput({name, " data"}, data, 32'h5A5A5A5A);
    checkOutput({name, " be"}, 32'(be), 32'h5);
    tbDrv = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    usb_wren_l  = v.wrenL;
    usb_outen_l = v.outenL;
    usb_rden_l  = v.rdenL;
    tbDrv       = !v.wrenL;
    tbData      = v.wrData;
    tbBe        = v.wrBe;
    tick();
  endtask

  task automatic writeWord(input logic [31:0] w);
    usb_wren_l = 1'b0;
    tbDrv      = 1'b1;
    tbData     = w;
    tbBe       = 4'hF;
    tick();
  endtask

  task automatic endWrite();
    usb_wren_l = 1'b1;
    tbDrv      = 1'b0;
    tick();
  endtask

  task automatic hostLoad(input logic [31:0] w);
    host_wr_valid = 1'b1;
    host_wr_data  = w;
    host_wr_be    = 4'hF;
    tick();
    host_wr_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h11111111, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 2'd2, 32'hFFFFFFFF};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 2'd2, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 4'h3, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0,        4'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0};

    rst = 1'b1;  usb_wren_l = 1'b1; usb_rden_l = 1'b1; usb_outen_l = 1'b1; usb_rst_l = 1'b1;
    host_wr_data = '0; host_wr_be = '0; host_wr_valid = 1'b0; host_rd_ready = 1'b0;
    tbDrv = 1'b0; tbData = '0; tbBe = '0;

    repeat (5) tick();
    checkBit("reset usb_txe", usb_txe, 1'b0);
    checkBit("reset usb_rxf", usb_rxf, 1'b1);
    checkBit("reset host_wr_ready", host_wr_ready, 1'b1);
    checkBit("reset host_rd_valid", host_rd_valid, 1'b0);
    checkBit("reset err_ovf", err_ovf, 1'b0);
    checkBit("reset err_unf", err_unf, 1'b0);
    checkBit("reset err_cont", err_cont, 1'b0);
    checkOutput("reset stat_wr_cnt", 32'(stat_wr_cnt), 32'd0);
    checkBusReleased("reset bus");
    rst = 1'b0;
    tick();

    // Contention, turnaround, underflow and one write from the vector table
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkBit($sformatf("vec%0d err_cont", i), err_cont, vecs[i].expCont);
      checkBit($sformatf("vec%0d err_unf", i), err_unf, vecs[i].expUnf);
      checkBit($sformatf("vec%0d err_ovf", i), err_ovf, 1'b0);
      checkBit($sformatf("vec%0d host_rd_valid", i), host_rd_valid, vecs[i].expRdValid);
      if (vecs[i].busMode == 2'd1)
        checkBusReleased($sformatf("vec%0d released", i));
      else if (vecs[i].busMode == 2'd2) begin
        checkOutput($sformatf("vec%0d data", i), data, vecs[i].expData);
        checkOutput($sformatf("vec%0d be", i), 32'(be), 32'hF);
      end
    end
    checkOutput("table word data", host_rd_data, 32'hCAFEF00D);
    checkOutput("table word be", 32'(host_rd_be), 32'h3);
    host_rd_ready = 1'b1;
    tick();
    host_rd_ready = 1'b0;
    checkBit("table drained", host_rd_valid, 1'b0);
    checkOutput("table stat_wr_cnt", 32'(stat_wr_cnt), expStat(1));

    // Read burst
    hostLoad(32'hFF00FF00);
    checkBit("burst rxf after load", usb_rxf, 1'b0);
    hostLoad(32'h12345678);
    usb_outen_l = 1'b0;
    tick();
    checkBusReleased("burst turn");
    tick();
    usb_rden_l = 1'b0;
    #1;
    checkOutput("burst word0", data, 32'hFF00FF00);
    checkOutput("burst be0", 32'(be), 32'hF);
    tick();
    checkOutput("burst word1", data, 32'h12345678);
    checkBit("burst rxf mid", usb_rxf, 1'b0);
    tick();
    usb_rden_l = 1'b1;
    checkBit("burst rxf end", usb_rxf, 1'b1);
    checkOutput("burst empty data", data, 32'hFFFFFFFF);
    checkOutput("burst stat_rd_cnt", 32'(stat_rd_cnt), expStat(2));
    usb_outen_l = 1'b1;
    checkBusReleased("burst release");
    tick();

    // Write fill past full
    for (int i = 0; i < 17; i++) begin
      writeWord(32'(i));
      if (i == 14) checkBit("fill txe at 15", usb_txe, 1'b0);
      if (i == 15) checkBit("fill txe at 16", usb_txe, 1'b1);
    end
    endWrite();
    checkBit("fill err_ovf", err_ovf, 1'b1);
    checkOutput("fill stat_wr_cnt", 32'(stat_wr_cnt), expStat(17));
    host_rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("fill drain %0d", k), host_rd_data, 32'(k));
      tick();
      if (k == 0) checkBit("fill txe after pop", usb_txe, 1'b0);
    end
    host_rd_ready = 1'b0;
    checkBit("fill drained", host_rd_valid, 1'b0);

    // Simultaneous bus push and host pop at occupancy 15
    for (int i = 0; i < 15; i++) writeWord(32'(100 + i));
    checkBit("sim txe at 15", usb_txe, 1'b0);
    host_rd_ready = 1'b1;
    checkOutput("sim head", host_rd_data, 32'd100);
    writeWord(32'd115);
    host_rd_ready = 1'b0;
    checkBit("sim txe after", usb_txe, 1'b0);
    writeWord(32'd116);
    checkBit("sim txe full", usb_txe, 1'b1);
    endWrite();
    host_rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("sim drain %0d", k), host_rd_data, 32'(101 + k));
      tick();
    end
    host_rd_ready = 1'b0;
    checkBit("sim drained", host_rd_valid, 1'b0);
    checkOutput("sim stat_wr_cnt", 32'(stat_wr_cnt), expStat(34));

    // Flush in the middle of a read, with a host push in the flush cycle
    for (int i = 0; i < 4; i++) hostLoad(32'hA0 + 32'(i));
    usb_outen_l = 1'b0;
    tick();
    tick();
    usb_rden_l = 1'b0;
    #1;
    checkOutput("flush word0", data, 32'hA0);
    tick();
    usb_rden_l = 1'b1;
    checkOutput("flush word1", data, 32'hA1);
    usb_rst_l     = 1'b0;
    host_wr_valid = 1'b1;
    host_wr_data  = 32'hBEEF;
    tick();
    usb_rst_l     = 1'b0 | 1'b1;
    host_wr_valid = 1'b0;
    checkBit("flush rxf", usb_rxf, 1'b1);
    checkBusReleased("flush idle");
    checkOutput("flush stat_rd_cnt", 32'(stat_rd_cnt), expStat(3));
    checkBit("flush keeps err_ovf", err_ovf, 1'b1);
    checkBit("flush keeps err_unf", err_unf, 1'b1);
    checkBit("flush keeps err_cont", err_cont, 1'b1);
    tick();
    checkBusReleased("flush turn");
    usb_outen_l = 1'b1;
    tick();

    // Reset clears sticky errors and counters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkBit("rst2 err_ovf", err_ovf, 1'b0);
    checkBit("rst2 err_cont", err_cont, 1'b0);
    checkOutput("rst2 stat_wr_cnt", 32'(stat_wr_cnt), 32'd0);
    checkOutput("rst2 stat_rd_cnt", 32'(stat_rd_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
